// File: rtl/ex_stage_alu.sv
// rtl/ex_stage_alu.sv - execute-stage ADD/SUB/pass-B ALU with NZCV flags and EX/MEM register
module ex_stage_alu #(
    parameter int WIDTH  = 64,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [2:0]        alu_cntrl,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              set_flags,
    input  logic [REG_AW-1:0] rd_in,
    input  logic              wr_en_in,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    output logic [WIDTH-1:0]  result,
    output logic              zero,
    output logic [REG_AW-1:0] rd_out,
    output logic              wr_en_out,
    output logic [3:0]        nzcv,
    output logic              illegal
);
    localparam logic [2:0] OP_PASS  = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_PASSZ = 3'b100;

    logic              is_pass, is_add, is_sub, is_legal, fire;
    logic [WIDTH-1:0]  op_b, alu_r;
    logic [WIDTH:0]    sum;
    logic              alu_c, alu_v, alu_z;

    logic              valid_q, valid_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              zero_q, zero_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [3:0]        nzcv_q, nzcv_d;
    logic              ill_q, ill_d;

    assign is_pass  = (alu_cntrl == OP_PASS) || (alu_cntrl == OP_PASSZ);
    assign is_add   = (alu_cntrl == OP_ADD);
    assign is_sub   = (alu_cntrl == OP_SUB);
    assign is_legal = is_pass || is_add || is_sub;
    assign fire     = in_valid && !stall && !flush;

    // Subtraction reuses the adder as a + ~b + 1 so carry-out means "no borrow".
    assign op_b = is_sub ? ~b : b;
    assign sum  = {1'b0, a} + {1'b0, op_b} + {{WIDTH{1'b0}}, is_sub};

    always_comb begin
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        if (is_pass) begin
            alu_r = b;
        end else if (is_add || is_sub) begin
            alu_r = sum[WIDTH-1:0];
            alu_c = sum[WIDTH];
            alu_v = (a[WIDTH-1] == op_b[WIDTH-1]) && (alu_r[WIDTH-1] != a[WIDTH-1]);
        end
    end

    assign alu_z = (alu_r == '0);

    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        zero_d   = zero_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        ill_d    = ill_q;
        nzcv_d   = nzcv_q;
        if (flush) begin
            valid_d = 1'b0;
            wr_d    = 1'b0;
            ill_d   = 1'b0;
        end else if (!stall) begin
            if (in_valid) begin
                valid_d  = 1'b1;
                result_d = alu_r;
                zero_d   = alu_z;
                rd_d     = rd_in;
                wr_d     = wr_en_in && is_legal;
                ill_d    = !is_legal;
            end else begin
                valid_d = 1'b0;
                wr_d    = 1'b0;
                ill_d   = 1'b0;
            end
        end
        if (fire && set_flags && is_legal) begin
            nzcv_d = {alu_r[WIDTH-1], alu_z, alu_c, alu_v};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            rd_q     <= '0;
            wr_q     <= 1'b0;
            nzcv_q   <= 4'b0000;
            ill_q    <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            nzcv_q   <= nzcv_d;
            ill_q    <= ill_d;
        end
    end

    assign out_valid = valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign rd_out    = rd_q;
    assign wr_en_out = wr_q;
    assign nzcv      = nzcv_q;
    assign illegal   = ill_q;
endmodule

// File: tb/tb_ex_stage_alu.sv
// tb/tb_ex_stage_alu.sv - directed and random checks of ex_stage_alu against a behavioural model
module tb_ex_stage_alu;
    localparam logic signed [65:0] MAXS = 66'sh0_7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [65:0] MINS = 66'sh3_8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset_n, in_valid, set_flags, wr_en_in, stall, flush;
    logic [2:0]  alu_cntrl;
    logic [63:0] a, b;
    logic [4:0]  rd_in;
    logic        out_valid, zero, wr_en_out, illegal;
    logic [63:0] result;
    logic [4:0]  rd_out;
    logic [3:0]  nzcv;

    int tests = 0;
    int fails = 0;
    bit model_on = 1'b0;

    logic        e_valid, e_zero, e_wr, e_ill;
    logic [63:0] e_result;
    logic [4:0]  e_rd;
    logic [3:0]  e_nzcv;

    always #5 clk = ~clk;

    ex_stage_alu #(.WIDTH(64), .REG_AW(5)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .alu_cntrl(alu_cntrl),
        .a(a), .b(b), .set_flags(set_flags), .rd_in(rd_in), .wr_en_in(wr_en_in),
        .stall(stall), .flush(flush), .out_valid(out_valid), .result(result),
        .zero(zero), .rd_out(rd_out), .wr_en_out(wr_en_out), .nzcv(nzcv), .illegal(illegal)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: signed overflow judged by whether the exact integer result fits in 64 bits.
    always @(posedge clk) begin
        logic [64:0]        full;
        logic signed [65:0] s;
        logic [63:0]        r;
        logic               c, v, legal;
        r = '0; c = 1'b0; v = 1'b0; legal = 1'b1;
        case (alu_cntrl)
            3'b000, 3'b100: r = b;
            3'b010: begin
                full = {1'b0, a} + {1'b0, b};
                r = full[63:0];
                c = full[64];
                s = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
                v = (s > MAXS) || (s < MINS);
            end
            3'b011: begin
                r = a - b;
                c = (a >= b);
                s = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
                v = (s > MAXS) || (s < MINS);
            end
            default: legal = 1'b0;
        endcase
        if (!reset_n) begin
            model_on = 1'b1;
            e_valid = 0; e_result = 0; e_zero = 1; e_rd = 0; e_wr = 0; e_nzcv = 0; e_ill = 0;
        end else if (flush) begin
            e_valid = 0; e_wr = 0; e_ill = 0;
        end else if (!stall) begin
            if (in_valid) begin
                e_valid = 1; e_result = r; e_zero = (r == 0); e_rd = rd_in;
                e_wr = wr_en_in && legal; e_ill = !legal;
                if (set_flags && legal) e_nzcv = {r[63], r == 0, c, v};
            end else begin
                e_valid = 0; e_wr = 0; e_ill = 0;
            end
        end
        #1;
        if (model_on) begin
            chk("m_valid", 64'(out_valid), 64'(e_valid));
            chk("m_result", result, e_result);
            chk("m_zero", 64'(zero), 64'(e_zero));
            chk("m_rd", 64'(rd_out), 64'(e_rd));
            chk("m_wr", 64'(wr_en_out), 64'(e_wr));
            chk("m_nzcv", 64'(nzcv), 64'(e_nzcv));
            chk("m_illegal", 64'(illegal), 64'(e_ill));
        end
    end

    task automatic drive(input logic v, input logic [2:0] op, input logic [63:0] xa,
                         input logic [63:0] xb, input logic sf, input logic [4:0] rd,
                         input logic we, input logic st, input logic fl);
        in_valid = v; alu_cntrl = op; a = xa; b = xb; set_flags = sf;
        rd_in = rd; wr_en_in = we; stall = st; flush = fl;
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset_n = 1'b0;
        // T1: a firing add under reset leaves everything at reset values
        drive(1, 3'b010, 5, 7, 1, 5'd9, 1, 0, 0);
        drive(1, 3'b010, 5, 7, 1, 5'd9, 1, 0, 0);
        chk("t1_valid", 64'(out_valid), 0);
        chk("t1_result", result, 0);
        chk("t1_zero", 64'(zero), 1);
        chk("t1_wr", 64'(wr_en_out), 0);
        chk("t1_nzcv", 64'(nzcv), 0);
        reset_n = 1'b1;
        drive(0, 3'b000, 0, 0, 0, 0, 0, 0, 0);

        // T2: add
        drive(1, 3'b010, 5, 7, 0, 5'd3, 1, 0, 0);
        chk("t2_result", result, 12);
        chk("t2_zero", 64'(zero), 0);
        chk("t2_rd", 64'(rd_out), 3);
        chk("t2_wr", 64'(wr_en_out), 1);
        chk("t2_nzcv", 64'(nzcv), 4'b0000);
        drive(1, 3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 1, 1, 5'd4, 1, 0, 0);
        chk("t2_ovf_result", result, 64'h8000_0000_0000_0000);
        chk("t2_ovf_nzcv", 64'(nzcv), 4'b1001);

        // T3: subs
        drive(1, 3'b011, 3, 3, 1, 5'd5, 1, 0, 0);
        chk("t3_result", result, 0);
        chk("t3_zero", 64'(zero), 1);
        chk("t3_nzcv", 64'(nzcv), 4'b0110);
        drive(1, 3'b011, 0, 1, 1, 5'd5, 1, 0, 0);
        chk("t3_borrow_result", result, ONES);
        chk("t3_borrow_nzcv", 64'(nzcv), 4'b1000);

        // T4: stall freezes, flush kills, then the held instruction fires once
        drive(1, 3'b011, 3, 3, 1, 5'd6, 1, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 3'b011, 0, 1, 1, 5'd7, 1, 1, 0);
        chk("t4_stall_result", result, 0);
        chk("t4_stall_valid", 64'(out_valid), 1);
        chk("t4_stall_nzcv", 64'(nzcv), 4'b0110);
        drive(1, 3'b011, 0, 1, 1, 5'd7, 1, 1, 1);
        chk("t4_flush_valid", 64'(out_valid), 0);
        chk("t4_flush_wr", 64'(wr_en_out), 0);
        chk("t4_flush_nzcv", 64'(nzcv), 4'b0110);
        drive(1, 3'b011, 0, 1, 1, 5'd7, 1, 0, 0);
        chk("t4_release_nzcv", 64'(nzcv), 4'b1000);

        // T5: CBZ pass-B zero test
        drive(1, 3'b100, 64'h55, 0, 0, 5'd1, 0, 0, 0);
        chk("t5_zero", 64'(zero), 1);
        chk("t5_result", result, 0);
        drive(1, 3'b100, 64'h55, 64'h40, 0, 5'd1, 0, 0, 0);
        chk("t5_nz_zero", 64'(zero), 0);
        chk("t5_nz_result", result, 64'h40);
        chk("t5_nzcv", 64'(nzcv), 4'b1000);
        drive(1, 3'b000, 64'h55, 0, 1, 5'd1, 1, 0, 0);
        chk("t5_passflags", 64'(nzcv), 4'b0100);

        // T6: illegal code
        drive(1, 3'b111, 5, 7, 1, 5'd2, 1, 0, 0);
        chk("t6_illegal", 64'(illegal), 1);
        chk("t6_wr", 64'(wr_en_out), 0);
        chk("t6_result", result, 0);
        chk("t6_nzcv", 64'(nzcv), 4'b0100);
        drive(0, 3'b111, 5, 7, 1, 5'd2, 1, 0, 0);
        chk("t6_bubble_illegal", 64'(illegal), 0);

        // Back-to-back mix with occasional stall/flush, checked by the model alone
        for (int i = 0; i < 60; i++) begin
            logic [2:0] op;
            logic [63:0] ra, rb;
            op = 3'($urandom_range(0, 7));
            ra = {$urandom, $urandom};
            rb = (i % 5 == 0) ? ra : {$urandom, $urandom};
            drive($urandom_range(0, 5) != 0, op, ra, rb, 1'($urandom), 5'($urandom),
                  1'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0);
        end

        // Reset in the middle of a stall/flush still wins
        reset_n = 1'b0;
        drive(1, 3'b010, 1, 1, 1, 5'd8, 1, 1, 1);
        chk("rst_valid", 64'(out_valid), 0);
        chk("rst_nzcv", 64'(nzcv), 0);
        chk("rst_zero", 64'(zero), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
